dff_ram_8x72_bist: RTL

//  March C- built-in self-test initiator for the 8x72 DFF RAM. Owns the RAM's write/address/data

---
 rtl/dff_ram_8x72_bist.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/dff_ram_8x72_bist.sv
// March C- self-test initiator for the 8x72 DFF RAM: drives every test read/write,
// compares read data through a latency-matched pipe and reports pass/fail plus first failure.
module dff_ram_8x72_bist #(
  parameter int                DATA_W     = 72,
  parameter int                ADDR_W     = 3,
  parameter int                RD_LATENCY = 1,
  parameter logic [DATA_W-1:0] BG_PATTERN = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [3:0]        fail_count,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [2:0]        fail_elem,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        dbg_state
);

  localparam int              DEPTH      = 1 << ADDR_W;
  localparam int              OP_W       = ADDR_W + 4;
  localparam logic [OP_W-1:0] OP_DEPTH   = OP_W'(DEPTH);
  localparam logic [OP_W-1:0] OP_LAST    = OP_W'(10 * DEPTH - 1);
  localparam logic [1:0]      DRAIN_LAST = 2'(RD_LATENCY);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [OP_W-1:0]     op_cnt_q, op_cnt_d;
  logic [1:0]          drain_cnt_q, drain_cnt_d;
  logic                busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [3:0]          fail_count_q, fail_count_d;
  logic [ADDR_W-1:0]   fail_addr_q, fail_addr_d;
  logic [2:0]          fail_elem_q, fail_elem_d;
  logic                mem_wr_q, mem_wr_d;
  logic [ADDR_W-1:0]   mem_address_q, mem_address_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;

  // Stage 0 lines up with the registered read address; the last stage lines up with mem_rdata.
  logic                pipe_vld_q  [RD_LATENCY+1];
  logic                pipe_vld_d  [RD_LATENCY+1];
  logic [DATA_W-1:0]   pipe_exp_q  [RD_LATENCY+1];
  logic [DATA_W-1:0]   pipe_exp_d  [RD_LATENCY+1];
  logic [ADDR_W-1:0]   pipe_addr_q [RD_LATENCY+1];
  logic [ADDR_W-1:0]   pipe_addr_d [RD_LATENCY+1];
  logic [2:0]          pipe_elem_q [RD_LATENCY+1];
  logic [2:0]          pipe_elem_d [RD_LATENCY+1];

  logic [OP_W-1:0]     k;
  logic [2:0]          grp;
  logic [2:0]          op_elem;
  logic [ADDR_W-1:0]   op_addr;
  logic                op_rd, op_one;
  logic                issue, miss;

  // Op index -> (element, address, read/write, data polarity). Groups 0..3 are the r/w elements E1..E4.
  always_comb begin
    k       = op_cnt_q - OP_DEPTH;
    grp     = k[OP_W-1:ADDR_W+1];
    op_elem = 3'd0;
    op_addr = op_cnt_q[ADDR_W-1:0];
    op_rd   = 1'b0;
    op_one  = 1'b0;
    if (op_cnt_q < OP_DEPTH) begin
      op_elem = 3'd0;
    end else if (grp < 3'd4) begin
      op_elem = grp + 3'd1;
      op_addr = k[ADDR_W:1];
      if (grp[1]) op_addr = ~op_addr;
      op_rd  = ~k[0];
      op_one = op_rd ? grp[0] : ~grp[0];
    end else begin
      op_elem = 3'd5;
      op_addr = k[ADDR_W-1:0];
      op_rd   = 1'b1;
    end
  end

  always_comb begin
    state_d       = state_q;
    op_cnt_d      = op_cnt_q;
    drain_cnt_d   = drain_cnt_q;
    busy_d        = busy_q;
    done_d        = done_q;
    pass_d        = pass_q;
    fail_count_d  = fail_count_q;
    fail_addr_d   = fail_addr_q;
    fail_elem_d   = fail_elem_q;
    mem_wr_d      = 1'b0;
    mem_address_d = mem_address_q;
    mem_wdata_d   = mem_wdata_q;
    issue         = 1'b0;

    pipe_vld_d[0]  = 1'b0;
    pipe_exp_d[0]  = pipe_exp_q[0];
    pipe_addr_d[0] = pipe_addr_q[0];
    pipe_elem_d[0] = pipe_elem_q[0];
    for (int i = 1; i <= RD_LATENCY; i++) begin
      pipe_vld_d[i]  = pipe_vld_q[i-1];
      pipe_exp_d[i]  = pipe_exp_q[i-1];
      pipe_addr_d[i] = pipe_addr_q[i-1];
      pipe_elem_d[i] = pipe_elem_q[i-1];
    end

    miss = pipe_vld_q[RD_LATENCY] && (mem_rdata != pipe_exp_q[RD_LATENCY]);
    if (miss) begin
      if (fail_count_q != 4'hF) fail_count_d = fail_count_q + 4'd1;
      if (fail_count_q == 4'd0) begin
        fail_addr_d = pipe_addr_q[RD_LATENCY];
        fail_elem_d = pipe_elem_q[RD_LATENCY];
      end
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d      = S_RUN;
          busy_d       = 1'b1;
          done_d       = 1'b0;
          pass_d       = 1'b0;
          fail_count_d = 4'd0;
          fail_addr_d  = '0;
          fail_elem_d  = 3'd0;
          issue        = 1'b1;
        end
      end
      S_RUN: begin
        issue = 1'b1;
        if (op_cnt_q == OP_LAST) begin
          state_d     = S_DRAIN;
          drain_cnt_d = 2'd0;
        end
      end
      S_DRAIN: begin
        drain_cnt_d = drain_cnt_q + 2'd1;
        if (drain_cnt_q == DRAIN_LAST) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (fail_count_d == 4'd0);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (issue) begin
      mem_wr_d      = ~op_rd;
      mem_address_d = op_addr;
      mem_wdata_d   = op_one ? ~BG_PATTERN : BG_PATTERN;
      op_cnt_d      = (op_cnt_q == OP_LAST) ? '0 : op_cnt_q + 1'b1;
      if (op_rd) begin
        pipe_vld_d[0]  = 1'b1;
        pipe_exp_d[0]  = op_one ? ~BG_PATTERN : BG_PATTERN;
        pipe_addr_d[0] = op_addr;
        pipe_elem_d[0] = op_elem;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      op_cnt_q      <= '0;
      drain_cnt_q   <= 2'd0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
      fail_count_q  <= 4'd0;
      fail_addr_q   <= '0;
      fail_elem_q   <= 3'd0;
      mem_wr_q      <= 1'b0;
      mem_address_q <= '0;
      mem_wdata_q   <= '0;
      pipe_vld_q    <= '{default: 1'b0};
      pipe_exp_q    <= '{default: '0};
      pipe_addr_q   <= '{default: '0};
      pipe_elem_q   <= '{default: '0};
    end else begin
      state_q       <= state_d;
      op_cnt_q      <= op_cnt_d;
      drain_cnt_q   <= drain_cnt_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      pass_q        <= pass_d;
      fail_count_q  <= fail_count_d;
      fail_addr_q   <= fail_addr_d;
      fail_elem_q   <= fail_elem_d;
      mem_wr_q      <= mem_wr_d;
      mem_address_q <= mem_address_d;
      mem_wdata_q   <= mem_wdata_d;
      pipe_vld_q    <= pipe_vld_d;
      pipe_exp_q    <= pipe_exp_d;
      pipe_addr_q   <= pipe_addr_d;
      pipe_elem_q   <= pipe_elem_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign fail_count  = fail_count_q;
  assign fail_addr   = fail_addr_q;
  assign fail_elem   = fail_elem_q;
  assign mem_wr      = mem_wr_q;
  assign mem_address = mem_address_q;
  assign mem_wdata   = mem_wdata_q;
  assign dbg_state   = state_q;

endmodule
